// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: state/owner encodings,
// default bus widths and a counter-width helper.
package mem_arbiter_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 8;

  typedef enum logic {
    ST_CPU = 1'b0,
    ST_DMA = 1'b1
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  // A counter that must reach n-1 needs at least one bit even when n == 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core, the DMA port, the arbiter and MEMORY.
// master = requesters/memory side, slave = arbiter side.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic [AW-1:0] cpu_addr;
  logic          cpu_we;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_rdy;

  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic          dma_we;
  logic [DW-1:0] dma_din;
  logic          dma_ack;
  logic [DW-1:0] dma_dout;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  logic          owner;

  modport master (
    output cpu_addr, cpu_we, cpu_din,
    output dma_req, dma_addr, dma_we, dma_din,
    output mem_dout,
    input  cpu_dout, cpu_rdy, dma_ack, dma_dout,
    input  mem_addr, mem_we, mem_din, owner
  );

  modport slave (
    input  cpu_addr, cpu_we, cpu_din,
    input  dma_req, dma_addr, dma_we, dma_din,
    input  mem_dout,
    output cpu_dout, cpu_rdy, dma_ack, dma_dout,
    output mem_addr, mem_we, mem_din, owner
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port MEMORY: the core runs at most
// MAX_CPU_RUN cycles while DMA waits, DMA holds the bus at most DMA_BURST cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int MAX_CPU_RUN = 4,
  parameter int DMA_BURST   = 2
) (
  input  logic          CLK,
  input  logic          R,
  mem_arbiter_if.slave  bus
);

  localparam int RW = cnt_width(MAX_CPU_RUN);
  localparam int BW = cnt_width(DMA_BURST);
  localparam logic [RW-1:0] RUN_LAST   = RW'(MAX_CPU_RUN - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(DMA_BURST - 1);

  arb_state_t    state_reg, state_next;
  logic [RW-1:0] run_cnt_reg, run_cnt_next;
  logic [BW-1:0] burst_cnt_reg, burst_cnt_next;

  logic [AW-1:0] addr_sel;
  logic [DW-1:0] din_sel;
  logic          we_sel;
  logic          cpu_rdy_c;
  logic          dma_ack_c;

  always_ff @(posedge CLK) begin
    if (R) begin
      state_reg     <= ST_CPU;
      run_cnt_reg   <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      run_cnt_reg   <= run_cnt_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    run_cnt_next   = run_cnt_reg;
    burst_cnt_next = burst_cnt_reg;
    addr_sel       = bus.cpu_addr;
    din_sel        = bus.cpu_din;
    we_sel         = bus.cpu_we;
    cpu_rdy_c      = 1'b1;
    dma_ack_c      = 1'b0;

    case (state_reg)
      ST_CPU: begin
        if (!bus.dma_req) begin
          run_cnt_next = '0;
        end else if (run_cnt_reg == RUN_LAST) begin
          state_next     = ST_DMA;
          burst_cnt_next = '0;
        end else begin
          run_cnt_next = run_cnt_reg + RW'(1);
        end
      end

      ST_DMA: begin
        // A withdrawn request leaves a dead cycle: nothing may be written.
        addr_sel  = bus.dma_addr;
        din_sel   = bus.dma_din;
        we_sel    = bus.dma_we & bus.dma_req;
        cpu_rdy_c = 1'b0;
        dma_ack_c = bus.dma_req;
        if (bus.dma_req && (burst_cnt_reg != BURST_LAST)) begin
          burst_cnt_next = burst_cnt_reg + BW'(1);
        end else begin
          state_next   = ST_CPU;
          run_cnt_next = '0;
        end
      end

      default: begin
        state_next = ST_CPU;
      end
    endcase
  end

  assign bus.mem_addr = addr_sel;
  assign bus.mem_din  = din_sel;
  assign bus.mem_we   = we_sel;
  assign bus.cpu_rdy  = cpu_rdy_c;
  assign bus.dma_ack  = dma_ack_c;
  assign bus.cpu_dout = bus.mem_dout;
  assign bus.dma_dout = bus.mem_dout;
  assign bus.owner    = (state_reg == ST_DMA) ? OWNER_DMA : OWNER_CPU;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter with a behavioural single-port memory;
// expected per-cycle status is queued at drive time and popped at the sample point.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic CLK = 1'b0;
  logic R   = 1'b1;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.AW(16), .DW(8)) bus ();

  mem_arbiter #(
    .AW(16), .DW(8), .MAX_CPU_RUN(4), .DMA_BURST(2)
  ) dut (
    .CLK (CLK),
    .R   (R),
    .bus (bus)
  );

  // Combinational-read, write-on-edge memory.
  logic [7:0] mem [0:65535];
  assign bus.mem_dout = mem[bus.mem_addr];
  always @(posedge CLK) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
  end

  // st = {owner, cpu_rdy, dma_ack, mem_we}; dsel: 0 none, 1 cpu_dout, 2 dma_dout
  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] addr;
    logic [1:0]  dsel;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(input logic [3:0] st, input logic [15:0] addr,
                              input logic [1:0] dsel, input logic [7:0] data);
    exp_t e;
    e.st = st; e.addr = addr; e.dsel = dsel; e.data = data;
    return e;
  endfunction

  task automatic drive(input logic [15:0] ca, input logic cw, input logic [7:0] cd,
                       input logic rq, input logic [15:0] da, input logic dw,
                       input logic [7:0] dd);
    bus.cpu_addr = ca; bus.cpu_we = cw; bus.cpu_din = cd;
    bus.dma_req  = rq; bus.dma_addr = da; bus.dma_we = dw; bus.dma_din = dd;
  endtask

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycle;
    drive(16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
    next_cycle();
  endtask

  task automatic test_reset;
    exp_t o;
    logic [3:0] st;
    R = 1'b1;
    drive(16'h0040, 1'b0, 8'h00, 1'b1, 16'h0050, 1'b1, 8'h77);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      sb.push_back(mk(4'b0100, 16'h0040, 2'd0, 8'h00));
      @(negedge CLK);
      o  = sb.pop_front();
      st = {bus.owner, bus.cpu_rdy, bus.dma_ack, bus.mem_we};
      checks++;
      if (st !== o.st || bus.mem_addr !== o.addr) begin
        errors++;
        $display("FAIL reset k=%0d st=%b addr=%h expected st=%b addr=%h", k, st, bus.mem_addr, o.st, o.addr);
      end else $display("ok reset k=%0d st=%b addr=%h", k, st, bus.mem_addr);
      next_cycle();
    end
    R = 1'b0;
    idle_cycle();
  endtask

  task automatic test_cpu_only;
    exp_t o;
    logic [3:0] st;
    for (int k = 0; k < 20; k++) begin
      drive(16'(k), 1'b0, 8'h00, 1'b0, 16'h0ABC, 1'b0, 8'h00);
      sb.push_back(mk(4'b0100, 16'(k), 2'd0, 8'h00));
      @(negedge CLK);
      o  = sb.pop_front();
      st = {bus.owner, bus.cpu_rdy, bus.dma_ack, bus.mem_we};
      checks++;
      if (st !== o.st || bus.mem_addr !== o.addr) begin
        errors++;
        $display("FAIL cpu_only k=%0d st=%b addr=%h expected st=%b addr=%h", k, st, bus.mem_addr, o.st, o.addr);
      end else $display("ok cpu_only k=%0d addr=%h", k, bus.mem_addr);
      next_cycle();
    end
  endtask

  task automatic test_dma_pattern;
    exp_t o;
    logic [3:0] st;
    logic own;
    for (int k = 0; k < 18; k++) begin
      own = ((k % 6) >= 4);
      drive(16'h1000 + 16'(k), 1'b0, 8'h00, 1'b1, 16'h2000 + 16'(k), 1'b0, 8'h00);
      sb.push_back(mk({own, !own, own, 1'b0}, own ? 16'h2000 + 16'(k) : 16'h1000 + 16'(k), 2'd0, 8'h00));
      @(negedge CLK);
      o  = sb.pop_front();
      st = {bus.owner, bus.cpu_rdy, bus.dma_ack, bus.mem_we};
      checks++;
      if (st !== o.st || bus.mem_addr !== o.addr) begin
        errors++;
        $display("FAIL dma_pattern k=%0d st=%b addr=%h expected st=%b addr=%h", k, st, bus.mem_addr, o.st, o.addr);
      end else $display("ok dma_pattern k=%0d owner=%b addr=%h", k, bus.owner, bus.mem_addr);
      next_cycle();
    end
    idle_cycle();
  endtask

  task automatic test_dma_write;
    exp_t o;
    logic [3:0] st;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: begin
          drive(16'h0200, 1'b1, 8'h00, 1'b1, 16'h0200, 1'b1, 8'h5A);
          sb.push_back(mk(4'b0101, 16'h0200, 2'd0, 8'h00));
        end
        1, 2, 3: begin
          drive(16'h0100 + 16'(k), 1'b0, 8'h00, 1'b1, 16'h0200, 1'b1, 8'h5A);
          sb.push_back(mk(4'b0100, 16'h0100 + 16'(k), 2'd0, 8'h00));
        end
        4: begin
          drive(16'h0104, 1'b0, 8'h00, 1'b1, 16'h0200, 1'b1, 8'h5A);
          sb.push_back(mk(4'b1011, 16'h0200, 2'd0, 8'h00));
        end
        5: begin
          drive(16'h0104, 1'b0, 8'h00, 1'b0, 16'h0200, 1'b1, 8'h5A);
          sb.push_back(mk(4'b1000, 16'h0200, 2'd0, 8'h00));
        end
        default: begin
          drive(16'h0200, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
          sb.push_back(mk(4'b0100, 16'h0200, 2'd1, 8'h5A));
        end
      endcase
      @(negedge CLK);
      o  = sb.pop_front();
      st = {bus.owner, bus.cpu_rdy, bus.dma_ack, bus.mem_we};
      checks++;
      if (st !== o.st || bus.mem_addr !== o.addr) begin
        errors++;
        $display("FAIL dma_write k=%0d st=%b addr=%h expected st=%b addr=%h", k, st, bus.mem_addr, o.st, o.addr);
      end else $display("ok dma_write k=%0d st=%b addr=%h", k, st, bus.mem_addr);
      if (o.dsel == 2'd1) begin
        checks++;
        if (bus.cpu_dout !== o.data) begin
          errors++;
          $display("FAIL dma_write_readback cpu_dout=%h expected %h", bus.cpu_dout, o.data);
        end else $display("ok dma_write_readback cpu_dout=%h", bus.cpu_dout);
      end
      next_cycle();
    end
    idle_cycle();
  endtask

  task automatic test_dma_drop;
    exp_t o;
    logic [3:0] st;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: begin
          drive(16'h0210, 1'b1, 8'h00, 1'b1, 16'h0210, 1'b1, 8'h11);
          sb.push_back(mk(4'b0101, 16'h0210, 2'd0, 8'h00));
        end
        1, 2, 3: begin
          drive(16'h0110 + 16'(k), 1'b0, 8'h00, 1'b1, 16'h0210, 1'b1, 8'h11);
          sb.push_back(mk(4'b0100, 16'h0110 + 16'(k), 2'd0, 8'h00));
        end
        4: begin
          drive(16'h0114, 1'b0, 8'h00, 1'b1, 16'h0210, 1'b1, 8'h11);
          sb.push_back(mk(4'b1011, 16'h0210, 2'd0, 8'h00));
        end
        5: begin
          // request withdrawn with write still asserted: must be a dead cycle
          drive(16'h0114, 1'b0, 8'h00, 1'b0, 16'h0210, 1'b1, 8'h22);
          sb.push_back(mk(4'b1000, 16'h0210, 2'd0, 8'h00));
        end
        default: begin
          drive(16'h0210, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
          sb.push_back(mk(4'b0100, 16'h0210, 2'd1, 8'h11));
        end
      endcase
      @(negedge CLK);
      o  = sb.pop_front();
      st = {bus.owner, bus.cpu_rdy, bus.dma_ack, bus.mem_we};
      checks++;
      if (st !== o.st || bus.mem_addr !== o.addr) begin
        errors++;
        $display("FAIL dma_drop k=%0d st=%b addr=%h expected st=%b addr=%h", k, st, bus.mem_addr, o.st, o.addr);
      end else $display("ok dma_drop k=%0d st=%b addr=%h", k, st, bus.mem_addr);
      if (o.dsel == 2'd1) begin
        checks++;
        if (bus.cpu_dout !== o.data) begin
          errors++;
          $display("FAIL dma_drop_readback cpu_dout=%h expected %h", bus.cpu_dout, o.data);
        end else $display("ok dma_drop_readback cpu_dout=%h", bus.cpu_dout);
      end
      next_cycle();
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid_burst;
    exp_t o;
    logic [3:0] st;
    logic own, rq;
    for (int k = 0; k < 25; k++) begin
      own = (k == 4 || k == 5 || k == 10 || k == 11 || k == 17 || k == 22 || k == 23);
      rq  = !(k == 12 || k == 24);
      R   = (k == 5 || k == 17);
      drive(16'h0130 + 16'(k), 1'b0, 8'h00, rq, 16'h0220, 1'b0, 8'h00);
      sb.push_back(mk({own, !own, own, 1'b0}, own ? 16'h0220 : 16'h0130 + 16'(k), 2'd0, 8'h00));
      @(negedge CLK);
      o  = sb.pop_front();
      st = {bus.owner, bus.cpu_rdy, bus.dma_ack, bus.mem_we};
      checks++;
      if (st !== o.st || bus.mem_addr !== o.addr) begin
        errors++;
        $display("FAIL reset_burst k=%0d st=%b addr=%h expected st=%b addr=%h", k, st, bus.mem_addr, o.st, o.addr);
      end else $display("ok reset_burst k=%0d R=%b owner=%b", k, R, bus.owner);
      next_cycle();
    end
    R = 1'b0;
    idle_cycle();
  endtask

  task automatic test_cpu_write_then_dma;
    exp_t o;
    logic [3:0] st;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: begin
          drive(16'h0301, 1'b1, 8'h33, 1'b1, 16'h0300, 1'b0, 8'h00);
          sb.push_back(mk(4'b0101, 16'h0301, 2'd0, 8'h00));
        end
        1, 2: begin
          drive(16'h0120 + 16'(k), 1'b0, 8'h00, 1'b1, 16'h0300, 1'b0, 8'h00);
          sb.push_back(mk(4'b0100, 16'h0120 + 16'(k), 2'd0, 8'h00));
        end
        3: begin
          drive(16'h0300, 1'b1, 8'hA5, 1'b1, 16'h0300, 1'b0, 8'h00);
          sb.push_back(mk(4'b0101, 16'h0300, 2'd0, 8'h00));
        end
        4, 5: begin
          // core keeps presenting a write while stalled; it must not land
          drive(16'h0301, 1'b1, 8'hEE, 1'b1, 16'h0300, 1'b0, 8'h00);
          sb.push_back(mk(4'b1010, 16'h0300, 2'd2, 8'hA5));
        end
        default: begin
          drive(16'h0301, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
          sb.push_back(mk(4'b0100, 16'h0301, 2'd1, 8'h33));
        end
      endcase
      @(negedge CLK);
      o  = sb.pop_front();
      st = {bus.owner, bus.cpu_rdy, bus.dma_ack, bus.mem_we};
      checks++;
      if (st !== o.st || bus.mem_addr !== o.addr) begin
        errors++;
        $display("FAIL cpu_wr_dma k=%0d st=%b addr=%h expected st=%b addr=%h", k, st, bus.mem_addr, o.st, o.addr);
      end else $display("ok cpu_wr_dma k=%0d st=%b addr=%h", k, st, bus.mem_addr);
      if (o.dsel == 2'd2) begin
        checks++;
        if (bus.dma_dout !== o.data || bus.dma_ack !== 1'b1) begin
          errors++;
          $display("FAIL cpu_wr_dma_read k=%0d dma_dout=%h ack=%b expected %h ack=1", k, bus.dma_dout, bus.dma_ack, o.data);
        end else $display("ok cpu_wr_dma_read k=%0d dma_dout=%h", k, bus.dma_dout);
      end else if (o.dsel == 2'd1) begin
        checks++;
        if (bus.cpu_dout !== o.data) begin
          errors++;
          $display("FAIL cpu_wr_stalled_write cpu_dout=%h expected %h", bus.cpu_dout, o.data);
        end else $display("ok cpu_wr_stalled_write cpu_dout=%h", bus.cpu_dout);
      end
      next_cycle();
    end
    idle_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(16'h0000, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
    test_reset();
    test_cpu_only();
    test_dma_pattern();
    test_dma_write();
    test_dma_drop();
    test_reset_mid_burst();
    test_cpu_write_then_dma();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover entries=%0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port MEMORY between two requesters: the 6502 core's fetch/operand bus, and a DMA port used by the program loader and the debug monitor.
- Grants one owner per cycle. Stalls the core through cpu_rdy while DMA owns the bus.
- Bounds DMA latency with a CPU run limit and bounds CPU stall with a DMA burst limit.
- Sits between the core's address/data bus and the MEMORY instance.

Parameters:
- AW, 16, address width.
- DW, 8, data width.
- MAX_CPU_RUN, 4, maximum consecutive CPU-owned cycles while dma_req is pending (must be >= 1).
- DMA_BURST, 2, maximum consecutive DMA-owned cycles (must be >= 1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- R  in  1  reset, synchronous, active-high.
- cpu_addr  in  AW  core address.
- cpu_we  in  1  core write enable.
- cpu_din  in  DW  core write data.
- cpu_dout  out  DW  read data to core.
- cpu_rdy  out  1  1 = core access performed this cycle; 0 = core must hold all state.
- dma_req  in  1  DMA access request, level, held with addr/we/din stable until acked.
- dma_addr  in  AW  DMA address.
- dma_we  in  1  DMA write enable.
- dma_din  in  DW  DMA write data.
- dma_ack  out  1  DMA access performed this cycle; requester advances on this.
- dma_dout  out  DW  DMA read data, valid when dma_ack=1.
- mem_addr  out  AW  to MEMORY Address.
- mem_we  out  1  to MEMORY WE.
- mem_din  out  DW  to MEMORY DataIn.
- mem_dout  in  DW  from MEMORY DataOut.
- owner  out  1  0 = CPU, 1 = DMA (debug/trace).

Behaviour:
- Memory model: read data is valid combinationally in the cycle the address is presented. A write commits on the rising CLK when mem_we=1.
- State register: ST_CPU (owner=0) and ST_DMA (owner=1). The state is registered. All outputs are combinational from state and inputs.
- Counters: run_cnt counts CPU cycles; burst_cnt counts DMA cycles. Each counter is sized for its parameter and saturates at parameter-1.
- Reset, applied on the rising edge with R=1, overrides everything including a burst in progress:
  - state=ST_CPU, run_cnt=0, burst_cnt=0.
  - After reset: cpu_rdy=1, dma_ack=0, owner=0.
  - mem_* follow cpu_*; cpu_dout and dma_dout = mem_dout.
- ST_CPU:
  - mem_addr/we/din = cpu_*; cpu_rdy=1; dma_ack=0.
  - If dma_req=0: run_cnt <= 0; stay in ST_CPU.
  - If dma_req=1 and run_cnt < MAX_CPU_RUN-1: run_cnt++.
  - If dma_req=1 and run_cnt == MAX_CPU_RUN-1: next ST_DMA, burst_cnt <= 0.
  - Result: with dma_req held, the CPU gets exactly MAX_CPU_RUN cycles after dma_req rises.
- ST_DMA:
  - mem_addr/we/din = dma_*; cpu_rdy=0.
  - dma_ack = dma_req (single cycle per access); dma_dout = mem_dout.
  - If dma_req=1 and burst_cnt < DMA_BURST-1: burst_cnt++; stay in ST_DMA.
  - If dma_req=1 and burst_cnt == DMA_BURST-1: next ST_CPU, run_cnt <= 0.
  - If dma_req=0 (requester withdrew or finished mid-burst): mem_we forced 0, dma_ack=0, next ST_CPU, run_cnt <= 0. This dead cycle is accepted.
- No write from a non-owner ever reaches MEMORY: mem_we=0 for the CPU whenever cpu_rdy=0.
- cpu_dout is always driven with mem_dout. The core ignores it while cpu_rdy=0.
- A DMA request that arrives while the core writes still waits its run slot; there is no preemption mid-cycle.

Decomposition:
- Shared include (cpu_defs.vh): ST_CPU/ST_DMA encodings, owner codes, AW/DW defaults. The core and monitor reuse these.
- Sub-modules: none. Both counters and the mux stay inline.
- Follow-on: the core's state register and prev_addr must gate on cpu_rdy.

Test Plan:
1. dma_req=0 for 20 cycles with core addresses 0x0000..0x0013 -> cpu_rdy=1 every cycle, owner=0, mem_addr==cpu_addr, dma_ack never 1.
2. Defaults (MAX_CPU_RUN=4, DMA_BURST=2), dma_req held high from cycle 0 -> owner pattern 0,0,0,0,1,1 repeating; dma_ack=1 exactly in owner=1 cycles; cpu_rdy=!owner.
3. DMA write 0x5A to 0x0200, dma_req released after ack, then core reads 0x0200 -> cpu_dout=0x5A; mem_we high only in the acked DMA cycle.
4. dma_req dropped after the first ack of a burst -> next cycle owner=1 with dma_ack=0 and mem_we=0 (dead cycle), then owner=0 and cpu_rdy=1.
5. R asserted during the second DMA cycle -> following cycle owner=0, cpu_rdy=1, dma_ack=0. With dma_req still high after R falls, DMA is regranted only after 4 full CPU cycles.
6. Core writes 0xA5 to 0x0300 in the cycle before a DMA grant, then DMA reads 0x0300 -> dma_dout=0xA5 with dma_ack=1. No CPU write occurs while cpu_rdy=0.
